// File: rtl/l1_read_arbiter_pkg.sv
// l1_read_arbiter_pkg: shared state type, port index type and priority encoder for the L1 read arbiter
package l1_read_arbiter_pkg;

    localparam int MAX_PORTS = 8;

    typedef enum logic [1:0] {IDLE, REQ, BURST} l1_arb_state_t;
    typedef logic [2:0] port_idx_t;

    function automatic port_idx_t priority_encoder(input logic [MAX_PORTS-1:0] v);
        priority_encoder = '0;
        for (int i = MAX_PORTS - 1; i >= 0; i--)
            if (v[i]) priority_encoder = port_idx_t'(i);
    endfunction

endpackage

// File: rtl/l1_read_arbiter_if.sv
// l1_read_arbiter_if: requester-side and L2-side read bus of the L1 read arbiter
interface l1_read_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W = 30,
    parameter int RLEN_W = 5
);
    logic [NUM_PORTS-1:0] req_request;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*RLEN_W-1:0] req_rlen;
    logic [NUM_PORTS-1:0] req_ack;
    logic [NUM_PORTS-1:0] req_rvalid;
    logic [31:0] req_rdata;
    logic l2_request;
    logic [ADDR_W-1:0] l2_addr;
    logic [RLEN_W-1:0] l2_rlen;
    logic l2_ack;
    logic l2_rvalid;
    logic [31:0] l2_rdata;

    modport master (
        output req_request, req_addr, req_rlen, l2_ack, l2_rvalid, l2_rdata,
        input req_ack, req_rvalid, req_rdata, l2_request, l2_addr, l2_rlen
    );

    modport slave (
        input req_request, req_addr, req_rlen, l2_ack, l2_rvalid, l2_rdata,
        output req_ack, req_rvalid, req_rdata, l2_request, l2_addr, l2_rlen
    );
endinterface

// File: rtl/l1_read_arbiter_rr_select.sv
// l1_read_arbiter_rr_select: combinational round-robin picker, first request at or above rr_ptr with wrap
module l1_read_arbiter_rr_select
    import l1_read_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input logic [NUM_PORTS-1:0] request,
    input port_idx_t rr_ptr,
    output logic [NUM_PORTS-1:0] grant,
    output port_idx_t grant_idx,
    output logic any
);
    logic [2*NUM_PORTS-1:0] doubled;
    logic [NUM_PORTS-1:0] rotated;
    port_idx_t offset;
    logic [3:0] sum;

    always_comb begin
        doubled = {request, request};
        rotated = NUM_PORTS'(doubled >> rr_ptr);
        offset = priority_encoder(MAX_PORTS'(rotated));
        sum = {1'b0, offset} + {1'b0, rr_ptr};
        grant_idx = (sum >= 4'(NUM_PORTS)) ? 3'(sum - 4'(NUM_PORTS)) : 3'(sum);
        any = |request;
        grant = any ? NUM_PORTS'(1) << grant_idx : '0;
    end
endmodule

// File: rtl/l1_read_arbiter.sv
// l1_read_arbiter: round-robin sharing of one single-outstanding L2 read burst port between requesters
module l1_read_arbiter
    import l1_read_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W = 30,
    parameter int RLEN_W = 5
) (
    input logic clk,
    input logic rst,
    l1_read_arbiter_if.slave bus
);
    l1_arb_state_t state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d, pick;
    port_idx_t grant_idx_q, grant_idx_d, rr_ptr_q, rr_ptr_d, pick_idx;
    logic [RLEN_W-1:0] burst_len_q, burst_len_d, beat_count_q, beat_count_d;
    logic any_req;

    l1_read_arbiter_rr_select #(.NUM_PORTS(NUM_PORTS)) u_rr_select (
        .request(bus.req_request),
        .rr_ptr(rr_ptr_q),
        .grant(pick),
        .grant_idx(pick_idx),
        .any(any_req)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            grant_idx_q <= '0;
            rr_ptr_q <= '0;
            burst_len_q <= '0;
            beat_count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q <= rr_ptr_d;
            burst_len_q <= burst_len_d;
            beat_count_q <= beat_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d = rr_ptr_q;
        burst_len_d = burst_len_q;
        beat_count_d = beat_count_q;
        case (state_q)
            IDLE: if (any_req) begin
                grant_d = pick;
                grant_idx_d = pick_idx;
                state_d = REQ;
            end
            REQ: if (bus.l2_ack) begin
                burst_len_d = bus.l2_rlen;
                beat_count_d = '0;
                rr_ptr_d = (grant_idx_q == port_idx_t'(NUM_PORTS - 1)) ? '0 : grant_idx_q + 3'd1;
                state_d = BURST;
            end
            BURST: if (bus.l2_rvalid) begin
                beat_count_d = beat_count_q + RLEN_W'(1);
                state_d = (beat_count_q == burst_len_q) ? IDLE : BURST;
            end
            default: state_d = IDLE;
        endcase
    end

    // l2_request decodes the state flop, so it follows the request by one cycle
    assign bus.l2_request = (state_q == REQ);
    assign bus.l2_addr = ADDR_W'(bus.req_addr >> (grant_idx_q * ADDR_W));
    assign bus.l2_rlen = RLEN_W'(bus.req_rlen >> (grant_idx_q * RLEN_W));
    assign bus.req_ack = (state_q == REQ && bus.l2_ack) ? grant_q : '0;
    assign bus.req_rvalid = (state_q == BURST && bus.l2_rvalid) ? grant_q : '0;
    assign bus.req_rdata = bus.l2_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!bus.l2_ack || bus.l2_request);
            assert (!bus.l2_rvalid || state_q == BURST);
            assert (state_q != REQ || |(bus.req_request & grant_q));
        end
    end
endmodule

// File: tb/tb_l1_read_arbiter.sv
// tb_l1_read_arbiter: directed self-checking bench for the L1 read arbiter
module tb_l1_read_arbiter;
    import l1_read_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int failures = 0;
    logic [29:0] addr [2];
    logic [4:0] rlen [2];

    always #5 clk = ~clk;

    l1_read_arbiter_if bus ();

    l1_read_arbiter dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive_ports;
        bus.req_addr = {addr[1], addr[0]};
        bus.req_rlen = {rlen[1], rlen[0]};
    endtask

    // Serves one burst for port p starting from IDLE with its request already high
    task automatic serve(input logic [1:0] m, input int p, input logic [31:0] base, input logic [1:0] raise);
        int n = int'(rlen[p]) + 1;
        chk("idle_l2_request", 32'(bus.l2_request), 32'd0);
        tick;
        chk("l2_request", 32'(bus.l2_request), 32'd1);
        chk("l2_addr", 32'(bus.l2_addr), 32'(addr[p]));
        chk("l2_rlen", 32'(bus.l2_rlen), 32'(rlen[p]));
        chk("ack_before_l2_ack", 32'(bus.req_ack), 32'd0);
        bus.l2_ack = 1'b1;
        #1;
        chk("req_ack", 32'(bus.req_ack), 32'(m));
        tick;
        bus.l2_ack = 1'b0;
        bus.req_request &= ~m;
        #1;
        chk("l2_request_drop", 32'(bus.l2_request), 32'd0);
        for (int b = 0; b < n; b++) begin
            if (b == 2) bus.req_request |= raise;
            bus.l2_rvalid = 1'b1;
            bus.l2_rdata = base + 32'(b);
            #1;
            chk("req_rvalid", 32'(bus.req_rvalid), 32'(m));
            chk("req_rdata", bus.req_rdata, base + 32'(b));
            tick;
        end
        bus.l2_rvalid = 1'b0;
        #1;
        chk("idle_after_burst", 32'(dut.state_q), 32'(IDLE));
    endtask

    initial begin
        rst = 1'b1;
        bus.req_request = '0;
        bus.l2_ack = 1'b0;
        bus.l2_rvalid = 1'b1;
        bus.l2_rdata = 32'h55;
        addr[0] = 30'h100;
        addr[1] = 30'h2345;
        rlen[0] = 5'd7;
        rlen[1] = 5'd0;
        drive_ports;
        tick;
        tick;
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_l2_request", 32'(bus.l2_request), 32'd0);
        chk("rst_req_ack", 32'(bus.req_ack), 32'd0);
        chk("rst_spurious_rvalid", 32'(bus.req_rvalid), 32'd0);
        chk("rst_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
        chk("rst_grant", 32'(dut.grant_q), 32'd0);
        rst = 1'b0;
        bus.l2_rvalid = 1'b0;
        tick;
        bus.req_request = 2'b01;
        #1;
        serve(2'b01, 0, 32'hA000, 2'b00);
        bus.req_request = 2'b10;
        #1;
        serve(2'b10, 1, 32'hDEADBEEF, 2'b00);
        rlen[1] = 5'd1;
        drive_ports;
        bus.req_request = 2'b11;
        #1;
        serve(2'b01, 0, 32'hB000, 2'b00);
        bus.req_request |= 2'b01;
        #1;
        serve(2'b10, 1, 32'hB100, 2'b00);
        bus.req_request |= 2'b10;
        #1;
        serve(2'b01, 0, 32'hB200, 2'b00);
        bus.req_request |= 2'b01;
        #1;
        serve(2'b10, 1, 32'hB300, 2'b00);
        serve(2'b01, 0, 32'hC000, 2'b10);
        serve(2'b10, 1, 32'hC100, 2'b00);
        bus.req_request = 2'b01;
        #1;
        tick;
        chk("mid_l2_request", 32'(bus.l2_request), 32'd1);
        bus.l2_ack = 1'b1;
        tick;
        bus.l2_ack = 1'b0;
        bus.req_request = 2'b00;
        for (int b = 0; b < 3; b++) begin
            bus.l2_rvalid = 1'b1;
            bus.l2_rdata = 32'hD000 + 32'(b);
            tick;
        end
        rst = 1'b1;
        tick;
        chk("mid_rst_l2_request", 32'(bus.l2_request), 32'd0);
        chk("mid_rst_req_rvalid", 32'(bus.req_rvalid), 32'd0);
        chk("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b0;
        bus.l2_rvalid = 1'b0;
        bus.req_request = 2'b01;
        #1;
        serve(2'b01, 0, 32'hE000, 2'b00);
        rlen[0] = 5'd31;
        drive_ports;
        bus.req_request = 2'b01;
        #1;
        serve(2'b01, 0, 32'hF000, 2'b00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
